// File: rtl/pc_watch_unit_if.sv
// Bundles the fetch tap, config write, register-file tap and record drain signals.
// The slave modport is the monitor's view; the master modport is the core/consumer side.
interface pc_watch_unit_if #(
  parameter int NUM_WP  = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STAMP_W = 32
);
  localparam int ID_W = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;

  logic [ADDR_W-1:0]    pc;
  logic                 pc_valid;
  logic                 cfg_we;
  logic [ID_W-1:0]      cfg_idx;
  logic                 cfg_en;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [4:0]           cfg_reg;
  logic [4:0]           rf_raddr;
  logic [DATA_W-1:0]    rf_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_W-1:0]      out_id;
  logic [STAMP_W-1:0]   out_stamp;
  logic [DATA_W-1:0]    out_data;
  logic [NUM_WP*16-1:0] hit_count;
  logic                 overflow;
  logic                 done;

  modport slave (
    input  pc, pc_valid, cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_reg, rf_rdata, out_ready,
    output rf_raddr, out_valid, out_id, out_stamp, out_data, hit_count, overflow, done
  );

  modport master (
    output pc, pc_valid, cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_reg, rf_rdata, out_ready,
    input  rf_raddr, out_valid, out_id, out_stamp, out_data, hit_count, overflow, done
  );
endinterface

// File: rtl/pc_watch_unit.sv
// Watchpoint monitor: first fetch of a watched pc queues {id, stamp, reg}; record visible next cycle.
// Drains on valid/ready; a hit on a full FIFO without a pop is dropped and sets sticky overflow.
module pc_watch_unit #(
  parameter int              NUM_WP     = 8,
  parameter int              FIFO_DEPTH = 16,
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              STAMP_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = '0
) (
  input logic             clk,
  input logic             reset,
  pc_watch_unit_if.slave  bus
);
  localparam int ID_W  = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [STAMP_W-1:0] stamp;
    logic [DATA_W-1:0]  data;
  } rec_t;

  logic [NUM_WP-1:0]  r_cfg_en;
  logic [ADDR_W-1:0]  r_cfg_addr [NUM_WP];
  logic [4:0]         r_cfg_reg  [NUM_WP];
  logic [15:0]        r_hit      [NUM_WP];
  logic [ADDR_W-1:0]  r_prev_pc;
  logic               r_prev_vld;
  logic [STAMP_W-1:0] r_stamp;
  logic               r_done;
  logic               r_overflow;
  rec_t               r_mem [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;

  logic                 w_new, w_active, w_halt, w_any;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [NUM_WP-1:0]    w_match;
  logic [ID_W-1:0]      w_low;
  logic [NUM_WP*16-1:0] w_hit_flat;
  rec_t                 w_rec, w_head;

  // A stalled pc is seen once: only a change (or the first valid fetch) qualifies.
  assign w_new    = bus.pc_valid && (!r_prev_vld || (bus.pc != r_prev_pc));
  assign w_active = w_new && !r_done;
  assign w_halt   = w_active && (bus.pc == HALT_ADDR);

  always_comb begin
    w_match = '0;
    w_low   = '0;
    for (int i = NUM_WP - 1; i >= 0; i--) begin
      w_match[i] = w_active && r_cfg_en[i] && (bus.pc == r_cfg_addr[i]);
      if (w_match[i]) w_low = ID_W'(i);
    end
  end

  assign w_any        = |w_match;
  assign bus.rf_raddr = w_any ? r_cfg_reg[w_low] : 5'd0;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = w_any && (!w_full || w_pop);

  assign w_rec  = '{id: w_low, stamp: r_stamp, data: bus.rf_rdata};
  assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign bus.out_valid = !w_empty;
  assign bus.out_id    = w_head.id;
  assign bus.out_stamp = w_head.stamp;
  assign bus.out_data  = w_head.data;
  assign bus.overflow  = r_overflow;
  assign bus.done      = r_done;

  always_comb begin
    w_hit_flat = '0;
    for (int i = 0; i < NUM_WP; i++) w_hit_flat[16*i +: 16] = r_hit[i];
  end
  assign bus.hit_count = w_hit_flat;

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_en   <= '0;
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
      r_stamp    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < NUM_WP; i++) begin
        r_cfg_addr[i] <= '0;
        r_cfg_reg[i]  <= '0;
        r_hit[i]      <= '0;
      end
    end else begin
      if (bus.pc_valid) begin
        r_prev_pc  <= bus.pc;
        r_prev_vld <= 1'b1;
      end
      if (!r_done) r_stamp <= r_stamp + STAMP_W'(1);
      if (w_halt) r_done <= 1'b1;
      if (w_any && !w_push) r_overflow <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      for (int i = 0; i < NUM_WP; i++) begin
        if (w_match[i] && (r_hit[i] != 16'hFFFF)) r_hit[i] <= r_hit[i] + 16'd1;
      end
      // The match above already used the pre-write entry values this cycle.
      if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_WP)) begin
        r_cfg_en[bus.cfg_idx]   <= bus.cfg_en;
        r_cfg_addr[bus.cfg_idx] <= bus.cfg_addr;
        r_cfg_reg[bus.cfg_idx]  <= bus.cfg_reg;
      end
    end
  end
endmodule

// File: tb/tb_pc_watch_unit.sv
// Directed bench for pc_watch_unit: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_pc_watch_unit;
  localparam int NUM_WP = 8;
  localparam int DEPTH  = 16;
  localparam logic [31:0] HALT = 32'h0;
  localparam logic [31:0] A0 = 32'h8002_0018;
  localparam logic [31:0] A1 = 32'h8002_001c;
  localparam logic [31:0] A2 = 32'h8002_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_watch_unit_if #(.NUM_WP(NUM_WP), .ADDR_W(32), .DATA_W(32), .STAMP_W(32)) bus ();

  pc_watch_unit #(
    .NUM_WP(NUM_WP), .FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .STAMP_W(32), .HALT_ADDR(HALT)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  function automatic logic [31:0] rf_val(input logic [4:0] r);
    return (r == 5'd2) ? 32'd5 : (32'h100 + 32'(r));
  endfunction

  assign bus.rf_rdata = rf_val(bus.rf_raddr);

  typedef struct { int id; logic [31:0] stamp; logic [31:0] data; } mrec_t;

  mrec_t       m_q[$];
  bit          m_en   [NUM_WP];
  logic [31:0] m_addr [NUM_WP];
  int          m_reg  [NUM_WP];
  int          m_cnt  [NUM_WP];
  logic [31:0] m_stamp, m_prev;
  bit          m_prev_vld, m_done, m_ovf, m_live;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [31:0] a);
    for (int i = 0; i < NUM_WP; i++) if (m_en[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic int exp_raddr();
    int l;
    if (!bus.pc_valid || m_done || (m_prev_vld && bus.pc == m_prev)) return 0;
    l = lowest(bus.pc);
    return (l < 0) ? 0 : m_reg[l];
  endfunction

  // Reference model: advances on each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit pop, newf, halt;
    int l;
    mrec_t r;
    if (rst) begin
      m_q.delete();
      m_stamp = '0; m_prev = '0; m_prev_vld = 0; m_done = 0; m_ovf = 0; m_live = 1;
      for (int i = 0; i < NUM_WP; i++) begin
        m_en[i] = 0; m_addr[i] = '0; m_reg[i] = 0; m_cnt[i] = 0;
      end
    end else if (m_live) begin
      pop  = (m_q.size() != 0) && bus.out_ready;
      newf = bus.pc_valid && (!m_prev_vld || bus.pc != m_prev);
      halt = 0;
      if (newf && !m_done) begin
        for (int i = 0; i < NUM_WP; i++)
          if (m_en[i] && m_addr[i] == bus.pc && m_cnt[i] < 65535) m_cnt[i]++;
        l = lowest(bus.pc);
        if (l >= 0) begin
          if (m_q.size() < DEPTH || pop) begin
            r.id = l; r.stamp = m_stamp; r.data = rf_val(5'(m_reg[l]));
            m_q.push_back(r);
          end else begin
            m_ovf = 1;
          end
        end
        halt = (bus.pc == HALT);
      end
      if (pop) void'(m_q.pop_front());
      if (bus.pc_valid) begin m_prev = bus.pc; m_prev_vld = 1; end
      if (!m_done) m_stamp++;
      if (halt) m_done = 1;
      if (bus.cfg_we) begin
        m_en[bus.cfg_idx]   = bus.cfg_en;
        m_addr[bus.cfg_idx] = bus.cfg_addr;
        m_reg[bus.cfg_idx]  = int'(bus.cfg_reg);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("out_valid", bus.out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("out_id", bus.out_id, m_q[0].id);
        chk("out_stamp", bus.out_stamp, m_q[0].stamp);
        chk("out_data", bus.out_data, m_q[0].data);
      end
      for (int i = 0; i < NUM_WP; i++) chk("hit_count", bus.hit_count[16*i +: 16], m_cnt[i]);
      chk("overflow", bus.overflow, m_ovf);
      chk("done", bus.done, m_done);
      chk("rf_raddr", bus.rf_raddr, exp_raddr());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.pc = a; bus.pc_valid = 1'b1;
    tick();
  endtask

  task automatic cfg(input int idx, input bit en, input logic [31:0] a, input int rg);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_en = en; bus.cfg_addr = a; bus.cfg_reg = 5'(rg);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.pc = '0; bus.pc_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
    bus.cfg_en = 1'b0; bus.cfg_addr = '0; bus.cfg_reg = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_hits_zero", |bus.hit_count, 0);

    // 1: single watchpoint, record next cycle with stamp 1 and r2 = 5
    cfg(0, 1, A0, 2);
    bus.pc = A0; bus.pc_valid = 1'b1;
    #1 chk("s1_raddr", bus.rf_raddr, 2);
    tick();
    chk("s1_valid", bus.out_valid, 1);
    chk("s1_id", bus.out_id, 0);
    chk("s1_stamp", bus.out_stamp, 1);
    chk("s1_data", bus.out_data, 5);
    chk("s1_hit0", bus.hit_count[15:0], 1);

    // 2: stalled pc hits once; leaving and returning hits again
    cfg(1, 1, A1, 3);
    fetch(A1); fetch(A1); fetch(A1);
    chk("s2_hit1_stall", bus.hit_count[31:16], 1);
    fetch(32'h8002_0000);
    fetch(A1);
    chk("s2_hit1_return", bus.hit_count[31:16], 2);
    chk("s2_id", bus.out_id, 1);
    chk("s2_data", bus.out_data, 32'h103);

    // 3: two entries on one address, lowest index records
    cfg(2, 1, A2, 4);
    cfg(5, 1, A2, 7);
    bus.pc = A2;
    #1 chk("s3_raddr", bus.rf_raddr, 4);
    tick();
    chk("s3_id", bus.out_id, 2);
    chk("s3_data", bus.out_data, 32'h104);
    chk("s3_hit2", bus.hit_count[47:32], 1);
    chk("s3_hit5", bus.hit_count[95:80], 1);

    // 4: fill FIFO, simultaneous push+pop when full, then overflow
    bus.pc_valid = 1'b0; tick(); tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) fetch((k % 2 == 0) ? A0 : A1);
    chk("s4_model_full", m_q.size(), DEPTH);
    chk("s4_no_ovf_full", bus.overflow, 0);
    chk("s4_head_id", bus.out_id, 0);
    bus.out_ready = 1'b1;
    fetch(A0);
    bus.out_ready = 1'b0;
    chk("s4_no_ovf_pushpop", bus.overflow, 0);
    chk("s4_still_full", m_q.size(), DEPTH);
    chk("s4_head_after_pop", bus.out_id, 1);
    fetch(A1);
    chk("s4_ovf", bus.overflow, 1);
    bus.out_ready = 1'b1; bus.pc_valid = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    chk("s4_drained", bus.out_valid, 0);

    // 5: halt address also watched; done freezes further activity
    bus.out_ready = 1'b0;
    fetch(A0); fetch(A1); fetch(A0);
    cfg(3, 1, HALT, 5);
    fetch(HALT);
    chk("s5_done", bus.done, 1);
    chk("s5_hit3", bus.hit_count[63:48], 1);
    fetch(A1); fetch(A0);
    chk("s5_hit0_frozen", bus.hit_count[15:0], 12);
    chk("s5_hit1_frozen", bus.hit_count[31:16], 12);
    chk("s5_queued", m_q.size(), 4);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; bus.pc_valid = 1'b0;
    chk("s5_head_after_drain", bus.out_id, 1);

    // 6: reset with queued records and done set; entries come back disabled
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_valid", bus.out_valid, 0);
    chk("s6_done", bus.done, 0);
    chk("s6_overflow", bus.overflow, 0);
    chk("s6_hits_zero", |bus.hit_count, 0);
    bus.out_ready = 1'b1;
    fetch(A0);
    chk("s6_disabled", bus.out_valid, 0);
    bus.pc = A1; bus.cfg_we = 1'b1; bus.cfg_idx = 3'd1; bus.cfg_en = 1'b1;
    bus.cfg_addr = A1; bus.cfg_reg = 5'd3;
    tick();
    bus.cfg_we = 1'b0;
    chk("s6_cfg_old_values", bus.out_valid, 0);
    fetch(A0); fetch(A1);
    chk("s6_new_hit", bus.out_valid, 1);
    chk("s6_new_id", bus.out_id, 1);
    chk("s6_stamp_restart", bus.out_stamp, 3);
    bus.pc_valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
